decode_unit: RTL and testbench
==============================

// Module: decode_unit
// PURPOSE
//  3-stage PowerPC instruction decoder between fetch and issue/rename. Classifies a
//  32-bit instruction into A-, B- or D-form, emits a one-hot format, opcode,
//  functional-unit class, operand access info and a packed operand body.
//  Sideband tags (address, 64-bit mode, PID, TID, major ID) travel with the instruction.
// PARAMETERS
//  addressWidth 64 | instructionWidth 32 | PidSize 20 | TidSize 16
//  instructionCounterWidth 64 (major ID) | instMinIdWidth 7 | opcodeSize 12
//  regSize 5 | regAccessPatternSize 2 | funcUnitCodeSize 3
// PORTS  (all vectors [0:N-1]; bit 0 = MSB, PowerPC numbering)
//  clock_i             in   1    sole clock, rising edge
//  reset_i             in   1    synchronous, active-high
//  enable_i            in   1    instruction_i valid this cycle
//  stall_i             in   1    hold all pipeline stages
//  instruction_i       in   32   instruction word
//  instructionAddress_i in  64 | is64Bit_i in 1 | instructionPid_i in 20
//  instructionTid_i    in   16 | instructionMajId_i in 64
//  enableOut           out  1    decoded result valid
//  instFormat_o        out  25   one-hot format: A=512, B=2, D=32; else 0
//  opcodeOut           out  12   {primary[0:5], 1'b0, xo[0:4]} (A-form); {primary, 6'b0} otherwise
//  addressOut/is64BitOut/pidOut/tidOut/majIDOut  out  tags copied through
//  funcUnitTypeOut     out  3    0 FXU, 1 LSU, 2 FPU, 3 BRU
//  minIDOut            out  7    always 0 (one micro-op per instruction)
//  op1rwOut..op4rwOut  out  2 each  [0]=read, [1]=written
//  op1IsRegOut..op4IsRegOut out 1 each  operand n is a register
//  bodyOut             out  84   packed operands, unused bits 0
// BEHAVIOUR
//  - Latency 3: instruction accepted at edge N is valid at outputs after edge N+2;
//    one output per accepted input; throughput 1/cycle. S1 latch, S2 format decode, S3 output mux.
//  - Reset (sync): all outputs and stage valids 0; in-flight instructions discarded.
//  - stall_i=1: no stage advances, outputs hold; reset overrides stall.
//  - A-form (24): op63 xo{18,20,21,22,23,24,25,26,28,29,30,31}; op59 same minus 23;
//    op31 xo15 (isel). body[0:4]=ins[6:10],[5:9]=[11:15],[10:14]=[16:20],[15:19]=[21:25],
//    [20]=ins[31] (Rc). FP: FPU, op1 write, op2-4 read, all regs.
//    isel: FXU, op4 (BC) IsReg=0.
//  - B-form (1): op16 bc. body[0:4]=BO,[5:9]=BI,[10:25]={BD ins[16:29],2'b00},[26]=AA,
//    [27]=LK. BRU; op1/op2 IsReg=0 (fields, not GPRs).
//  - D-form (40): op 2,3,7,8,10-15,24-29,32-55. body[0:4]=ins[6:10],[5:9]=ins[11:15],
//    [10:73]=64-bit imm: zero-extended for 10,24,26,28; imm<<16 zero-ext for 25,27,29;
//    imm<<16 sign-ext for 15; sign-extended otherwise.
//    32-55 LSU (loads write op1, stores read op1; update forms op2 read+write);
//    others FXU (2,3,10,11 op1 IsReg=0).
//  - Any other encoding: instFormat_o=0, enableOut=0 (dropped) unless ILLEGAL_TRAP_EN.
//  - Tags delayed identically to the instruction.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined: unsupported encodings emit enableOut=1, instFormat_o=0,
//  funcUnitTypeOut=7, bodyOut={instruction_i,52'b0}. Undefined: silently dropped.
// STRUCTURE
//  decode_pkg: format one-hot constants, func-unit codes, rw codes, opcode tables.
//  One sub-module decode_d_format (40-entry table + immediate extension); A/B inline.
// TESTING
//  - op63 xo21 enable 1 cycle -> enableOut=1 after exactly 3rd edge only, for one cycle.
//  - Sweep op 0-63 x xo 0-31, regs 31/0/31/0, Rc=xo%2 -> exactly 24 give format 512
//    with body fields matching.
//  - Sweep op, BO=31, BI=0, BD=0x3C0F -> only op16 gives format 2,
//    body[10:25]=0xF03C, AA/LK copied.
//  - Sweep op, imm=0xF00F -> 40 give format 32;
//    op14 imm=0xFFFFFFFFFFFFF00F, op24 imm=0xF00F, op15 imm=0xFFFFFFFFF00F0000.
//  - stall_i held 2 cycles mid-flight -> output delayed 2 cycles, not duplicated/lost.
//  - reset_i during flight -> enableOut stays 0, all outputs 0 next cycle.

Source files
------------

// File: rtl/decode_pkg.sv
// decode_pkg: widths, format/unit/access codes, opcode tables and stage payload structs
// shared by the PowerPC decoder. Vectors use PowerPC numbering (bit 0 = MSB).
package decode_pkg;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned INSN_W = 32;
    localparam int unsigned PID_W  = 20;
    localparam int unsigned TID_W  = 16;
    localparam int unsigned MAJ_W  = 64;
    localparam int unsigned MIN_W  = 7;
    localparam int unsigned OPC_W  = 12;
    localparam int unsigned RW_W   = 2;
    localparam int unsigned FU_W   = 3;
    localparam int unsigned FMT_W  = 25;
    localparam int unsigned BODY_W = 84;
    localparam int unsigned IMM_W  = 64;

    typedef logic [0:RW_W-1] rw_t;
    typedef logic [0:FU_W-1] fu_t;

    // One-hot format codes (numeric values of the 25-bit format vector)
    localparam logic [0:FMT_W-1] FMT_NONE = 25'd0;
    localparam logic [0:FMT_W-1] FMT_B    = 25'd2;
    localparam logic [0:FMT_W-1] FMT_D    = 25'd32;
    localparam logic [0:FMT_W-1] FMT_A    = 25'd512;

    localparam fu_t FU_FXU = 3'd0;
    localparam fu_t FU_LSU = 3'd1;
    localparam fu_t FU_FPU = 3'd2;
    localparam fu_t FU_BRU = 3'd3;
    localparam fu_t FU_ILL = 3'd7;

    // Bit 0 of the access code is "read", bit 1 is "written"
    localparam rw_t RW_NONE  = 2'b00;
    localparam rw_t RW_READ  = 2'b10;
    localparam rw_t RW_WRITE = 2'b01;
    localparam rw_t RW_BOTH  = 2'b11;

    // Bit n set => primary opcode n is D-form (2,3,7,8,10-15,24-29,32-55)
    localparam logic [63:0] D_FORM_OPS = 64'h00FF_FFFF_3F00_FD8C;
    // Bit n set => A-form xo n is legal under primary 63 / 59
    localparam logic [31:0] A_XO_OP63  = 32'hF7F4_0000;
    localparam logic [31:0] A_XO_OP59  = 32'hF774_0000;
    localparam logic [0:5]  OP_ISEL    = 6'd31;
    localparam logic [0:4]  XO_ISEL    = 5'd15;
    localparam logic [0:5]  OP_BC      = 6'd16;

    typedef struct packed {
        logic [0:ADDR_W-1] addr;
        logic              is64;
        logic [0:PID_W-1]  pid;
        logic [0:TID_W-1]  tid;
        logic [0:MAJ_W-1]  maj_id;
    } tag_t;

    typedef struct packed {
        logic              emit;
        logic [0:FMT_W-1]  fmt;
        logic [0:OPC_W-1]  opcode;
        fu_t               fu;
        rw_t               rw1;
        rw_t               rw2;
        rw_t               rw3;
        rw_t               rw4;
        logic              is_reg1;
        logic              is_reg2;
        logic              is_reg3;
        logic              is_reg4;
        logic [0:BODY_W-1] body;
    } dec_t;

    // Stores among the 32-55 load/store block
    function automatic logic lsu_is_store(input logic [0:5] op);
        return op inside {6'd36, 6'd37, 6'd38, 6'd39, 6'd44, 6'd45, 6'd47, [6'd52:6'd55]};
    endfunction

endpackage

// File: rtl/decode_d_format.sv
// decode_d_format: D-form opcode table lookup, unit/operand classification and
// 64-bit immediate extension.
module decode_d_format
    import decode_pkg::*;
(
    input  logic [0:5]       opcode,
    input  logic [0:15]      imm_field,
    output logic             hit_c,
    output fu_t              fu_c,
    output rw_t              rw1_c,
    output rw_t              rw2_c,
    output logic             is_reg1_c,
    output logic [0:IMM_W-1] imm_c
);

    // Classify the primary opcode and extend its immediate
    always_comb begin
        hit_c     = D_FORM_OPS[opcode];
        fu_c      = FU_FXU;
        rw1_c     = RW_WRITE;
        rw2_c     = RW_READ;
        is_reg1_c = 1'b1;
        imm_c     = {{48{imm_field[0]}}, imm_field};
        case (opcode)
            6'd2, 6'd3: begin
                rw1_c     = RW_NONE;
                is_reg1_c = 1'b0;
            end
            6'd10: begin
                is_reg1_c = 1'b0;
                imm_c     = {48'b0, imm_field};
            end
            6'd11: is_reg1_c = 1'b0;
            6'd15: imm_c = {{32{imm_field[0]}}, imm_field, 16'b0};
            6'd24, 6'd26, 6'd28: begin
                rw1_c = RW_READ;
                rw2_c = RW_WRITE;
                imm_c = {48'b0, imm_field};
            end
            6'd25, 6'd27, 6'd29: begin
                rw1_c = RW_READ;
                rw2_c = RW_WRITE;
                imm_c = {32'b0, imm_field, 16'b0};
            end
            default: begin
                if (opcode >= 6'd32 && opcode <= 6'd55) begin
                    fu_c  = FU_LSU;
                    rw1_c = lsu_is_store(opcode) ? RW_READ : RW_WRITE;
                    // Odd opcodes are update forms, except stmw (47)
                    rw2_c = (opcode[5] && opcode != 6'd47) ? RW_BOTH : RW_READ;
                end
            end
        endcase
    end

endmodule

// File: rtl/decode_unit.sv
// decode_unit: 3-stage PowerPC decoder (S1 latch, S2 format decode, S3 output register).
// Optional feature: define ILLEGAL_TRAP_EN to emit unsupported encodings as trap
// micro-ops instead of dropping them.
module decode_unit
    import decode_pkg::*;
(
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               enable_i,
    input  logic               stall_i,
    input  logic [0:INSN_W-1]  instruction_i,
    input  logic [0:ADDR_W-1]  instructionAddress_i,
    input  logic               is64Bit_i,
    input  logic [0:PID_W-1]   instructionPid_i,
    input  logic [0:TID_W-1]   instructionTid_i,
    input  logic [0:MAJ_W-1]   instructionMajId_i,
    output logic               enableOut,
    output logic [0:FMT_W-1]   instFormat_o,
    output logic [0:OPC_W-1]   opcodeOut,
    output logic [0:ADDR_W-1]  addressOut,
    output logic               is64BitOut,
    output logic [0:PID_W-1]   pidOut,
    output logic [0:TID_W-1]   tidOut,
    output logic [0:MAJ_W-1]   majIDOut,
    output logic [0:FU_W-1]    funcUnitTypeOut,
    output logic [0:MIN_W-1]   minIDOut,
    output logic [0:RW_W-1]    op1rwOut,
    output logic [0:RW_W-1]    op2rwOut,
    output logic [0:RW_W-1]    op3rwOut,
    output logic [0:RW_W-1]    op4rwOut,
    output logic               op1IsRegOut,
    output logic               op2IsRegOut,
    output logic               op3IsRegOut,
    output logic               op4IsRegOut,
    output logic [0:BODY_W-1]  bodyOut
);

`ifdef ILLEGAL_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    logic              s1_valid;
    logic [0:INSN_W-1] s1_ins;
    tag_t              s1_tag, s2_tag, out_tag, in_tag_c;
    dec_t              s2_dec, out_dec, dec_c;

    logic [0:5]        primary;
    logic [0:4]        xo;
    logic              a_hit;
    logic              d_hit;
    fu_t               d_fu;
    rw_t               d_rw1, d_rw2;
    logic              d_is_reg1;
    logic [0:IMM_W-1]  d_imm;

    assign in_tag_c = {instructionAddress_i, is64Bit_i, instructionPid_i,
                       instructionTid_i, instructionMajId_i};

    assign primary = s1_ins[0:5];
    assign xo      = s1_ins[26:30];
    assign a_hit   = (primary == 6'd63 && A_XO_OP63[xo]) ||
                     (primary == 6'd59 && A_XO_OP59[xo]) ||
                     (primary == OP_ISEL && xo == XO_ISEL);

    decode_d_format u_d_format (
        .opcode    (primary),
        .imm_field (s1_ins[16:31]),
        .hit_c     (d_hit),
        .fu_c      (d_fu),
        .rw1_c     (d_rw1),
        .rw2_c     (d_rw2),
        .is_reg1_c (d_is_reg1),
        .imm_c     (d_imm)
    );

    // S1: latch the incoming instruction and its tags
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            s1_valid <= 1'b0;
            s1_ins   <= '0;
            s1_tag   <= '0;
        end else if (!stall_i) begin
            s1_valid <= enable_i;
            s1_ins   <= instruction_i;
            s1_tag   <= in_tag_c;
        end
    end

    // Format classification and operand packing of the S1 instruction
    always_comb begin
        dec_c        = '0;
        dec_c.opcode = {primary, 6'b0};
        if (a_hit) begin
            dec_c.emit        = s1_valid;
            dec_c.fmt         = FMT_A;
            dec_c.opcode      = {primary, 1'b0, xo};
            dec_c.body[0:4]   = s1_ins[6:10];
            dec_c.body[5:9]   = s1_ins[11:15];
            dec_c.body[10:14] = s1_ins[16:20];
            dec_c.body[15:19] = s1_ins[21:25];
            dec_c.body[20]    = s1_ins[31];
            dec_c.fu          = (primary == OP_ISEL) ? FU_FXU : FU_FPU;
            dec_c.rw1         = RW_WRITE;
            dec_c.rw2         = RW_READ;
            dec_c.rw3         = RW_READ;
            dec_c.rw4         = RW_READ;
            dec_c.is_reg1     = 1'b1;
            dec_c.is_reg2     = 1'b1;
            dec_c.is_reg3     = 1'b1;
            dec_c.is_reg4     = (primary != OP_ISEL);
        end else if (primary == OP_BC) begin
            dec_c.emit        = s1_valid;
            dec_c.fmt         = FMT_B;
            dec_c.body[0:4]   = s1_ins[6:10];
            dec_c.body[5:9]   = s1_ins[11:15];
            dec_c.body[10:25] = {s1_ins[16:29], 2'b00};
            dec_c.body[26]    = s1_ins[30];
            dec_c.body[27]    = s1_ins[31];
            dec_c.fu          = FU_BRU;
            dec_c.rw1         = RW_READ;
            dec_c.rw2         = RW_READ;
        end else if (d_hit) begin
            dec_c.emit        = s1_valid;
            dec_c.fmt         = FMT_D;
            dec_c.body[0:4]   = s1_ins[6:10];
            dec_c.body[5:9]   = s1_ins[11:15];
            dec_c.body[10:73] = d_imm;
            dec_c.fu          = d_fu;
            dec_c.rw1         = d_rw1;
            dec_c.rw2         = d_rw2;
            dec_c.is_reg1     = d_is_reg1;
            dec_c.is_reg2     = 1'b1;
        end else begin
            dec_c.emit = s1_valid && TRAP_EN;
            dec_c.fu   = FU_ILL;
            dec_c.body = {s1_ins, 52'b0};
        end
    end

    // S2: hold the decoded payload; emit doubles as the stage valid
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            s2_dec <= '0;
            s2_tag <= '0;
        end else if (!stall_i) begin
            s2_dec <= dec_c;
            s2_tag <= s1_tag;
        end
    end

    // S3: output register, zeroed for bubbles and dropped encodings
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            out_dec <= '0;
            out_tag <= '0;
        end else if (!stall_i) begin
            out_dec <= s2_dec.emit ? s2_dec : '0;
            out_tag <= s2_dec.emit ? s2_tag : '0;
        end
    end

    assign enableOut       = out_dec.emit;
    assign instFormat_o    = out_dec.fmt;
    assign opcodeOut       = out_dec.opcode;
    assign funcUnitTypeOut = out_dec.fu;
    assign op1rwOut        = out_dec.rw1;
    assign op2rwOut        = out_dec.rw2;
    assign op3rwOut        = out_dec.rw3;
    assign op4rwOut        = out_dec.rw4;
    assign op1IsRegOut     = out_dec.is_reg1;
    assign op2IsRegOut     = out_dec.is_reg2;
    assign op3IsRegOut     = out_dec.is_reg3;
    assign op4IsRegOut     = out_dec.is_reg4;
    assign bodyOut         = out_dec.body;
    assign addressOut      = out_tag.addr;
    assign is64BitOut      = out_tag.is64;
    assign pidOut          = out_tag.pid;
    assign tidOut          = out_tag.tid;
    assign majIDOut        = out_tag.maj_id;
    assign minIDOut        = '0;

endmodule

// File: tb/tb_decode_unit.sv
// tb_decode_unit: directed self-checking bench for decode_unit.
// Expectations follow ILLEGAL_TRAP_EN when the bench is built with it.
module tb_decode_unit;

    logic        clock, reset, enable, stall;
    logic [0:31] instruction;
    logic [0:63] address;
    logic        is64;
    logic [0:19] pid;
    logic [0:15] tid;
    logic [0:63] maj;

    logic        en_out;
    logic [0:24] fmt_out;
    logic [0:11] opc_out;
    logic [0:63] addr_out;
    logic        is64_out;
    logic [0:19] pid_out;
    logic [0:15] tid_out;
    logic [0:63] maj_out;
    logic [0:2]  fu_out;
    logic [0:6]  min_out;
    logic [0:1]  rw1, rw2, rw3, rw4;
    logic        reg1, reg2, reg3, reg4;
    logic [0:83] body_out;

    int errors = 0;
    int checks = 0;

    decode_unit dut (
        .clock_i              (clock),
        .reset_i              (reset),
        .enable_i             (enable),
        .stall_i              (stall),
        .instruction_i        (instruction),
        .instructionAddress_i (address),
        .is64Bit_i            (is64),
        .instructionPid_i     (pid),
        .instructionTid_i     (tid),
        .instructionMajId_i   (maj),
        .enableOut            (en_out),
        .instFormat_o         (fmt_out),
        .opcodeOut            (opc_out),
        .addressOut           (addr_out),
        .is64BitOut           (is64_out),
        .pidOut               (pid_out),
        .tidOut               (tid_out),
        .majIDOut             (maj_out),
        .funcUnitTypeOut      (fu_out),
        .minIDOut             (min_out),
        .op1rwOut             (rw1),
        .op2rwOut             (rw2),
        .op3rwOut             (rw3),
        .op4rwOut             (rw4),
        .op1IsRegOut          (reg1),
        .op2IsRegOut          (reg2),
        .op3IsRegOut          (reg3),
        .op4IsRegOut          (reg4),
        .bodyOut              (body_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one instruction for a single cycle, then wait until it reaches the outputs
    task automatic issue(input logic [0:31] ins);
        instruction = ins;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        tick();
    endtask

    function automatic logic [0:31] mk_a(input int op, input int xo, input int rc);
        logic [0:31] w;
        w = '0;
        w[0:5]   = 6'(op);
        w[6:10]  = 5'd31;
        w[16:20] = 5'd31;
        w[26:30] = 5'(xo);
        w[31]    = 1'(rc);
        return w;
    endfunction

    function automatic logic [0:31] mk_b(input int op, input logic aa, input logic lk);
        logic [0:31] w;
        w[0:5]   = 6'(op);
        w[6:10]  = 5'd31;
        w[11:15] = 5'd0;
        w[16:29] = 14'h3C0F;
        w[30]    = aa;
        w[31]    = lk;
        return w;
    endfunction

    function automatic logic [0:31] mk_d(input int op);
        logic [0:31] w;
        w[0:5]   = 6'(op);
        w[6:10]  = 5'd3;
        w[11:15] = 5'd4;
        w[16:31] = 16'hF00F;
        return w;
    endfunction

    function automatic logic model_is_a(input int op, input int xo);
        return (op == 63 && xo inside {18, 20, 21, 22, 23, 24, 25, 26, 28, 29, 30, 31}) ||
               (op == 59 && xo inside {18, 20, 21, 22, 24, 25, 26, 28, 29, 30, 31}) ||
               (op == 31 && xo == 15);
    endfunction

    function automatic logic model_is_d(input int op);
        return op inside {2, 3, 7, 8, [10:15], [24:29], [32:55]};
    endfunction

    function automatic logic [0:63] model_imm(input int op, input logic [0:15] imm);
        if (op inside {10, 24, 26, 28}) return {48'b0, imm};
        if (op inside {25, 27, 29})     return {32'b0, imm, 16'b0};
        if (op == 15)                   return {{32{imm[0]}}, imm, 16'b0};
        return {{48{imm[0]}}, imm};
    endfunction

    task automatic test_reset();
        reset = 1'b1; stall = 1'b1; enable = 1'b1;
        instruction = mk_a(63, 21, 1);
        address = 64'h1; is64 = 1'b1; pid = 20'h1; tid = 16'h1; maj = 64'h1;
        tick(); tick(); tick();
        checks++; if (en_out !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", en_out); end
        checks++; if (fmt_out !== 25'd0) begin errors++; $display("FAIL reset_fmt: got %0d want 0", fmt_out); end
        checks++; if (body_out !== 84'd0) begin errors++; $display("FAIL reset_body: got %h want 0", body_out); end
        checks++; if (maj_out !== 64'd0) begin errors++; $display("FAIL reset_maj: got %h want 0", maj_out); end
        reset = 1'b0; stall = 1'b0; enable = 1'b0;
        tick();
        checks++; if (en_out !== 1'b0) begin errors++; $display("FAIL reset_release_en: got %b want 0", en_out); end
    endtask

    task automatic test_latency();
        logic [0:3] exp_en;
        exp_en = 4'b0010;
        instruction = mk_a(63, 21, 1);
        address = 64'h0123_4567_89AB_CDEF; is64 = 1'b1; pid = 20'hABCDE;
        tid = 16'h1234; maj = 64'hDEAD_BEEF_0000_0042;
        enable = 1'b1;
        for (int e = 0; e < 4; e++) begin
            tick();
            if (e == 0) begin
                enable = 1'b0;
                address = 64'h5; is64 = 1'b0; pid = 20'h5; tid = 16'h5; maj = 64'h5;
            end
            checks++;
            if (en_out !== exp_en[e]) begin errors++; $display("FAIL latency_en edge%0d: got %b want %b", e + 1, en_out, exp_en[e]); end
            if (e == 2) begin
                checks++; if (fmt_out !== 25'd512) begin errors++; $display("FAIL latency_fmt: got %0d want 512", fmt_out); end
                checks++; if (opc_out !== 12'hFD5) begin errors++; $display("FAIL latency_opcode: got %h want fd5", opc_out); end
                checks++; if (fu_out !== 3'd2) begin errors++; $display("FAIL latency_fu: got %0d want 2", fu_out); end
                checks++; if (addr_out !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL tag_addr: got %h want 0123456789abcdef", addr_out); end
                checks++; if ({is64_out, pid_out, tid_out} !== {1'b1, 20'hABCDE, 16'h1234}) begin
                    errors++; $display("FAIL tag_misc: got %b %h %h want 1 abcde 1234", is64_out, pid_out, tid_out); end
                checks++; if (maj_out !== 64'hDEAD_BEEF_0000_0042) begin errors++; $display("FAIL tag_maj: got %h want deadbeef00000042", maj_out); end
                checks++; if (min_out !== 7'd0) begin errors++; $display("FAIL min_id: got %0d want 0", min_out); end
                checks++; if ({rw1, rw2, rw3, rw4} !== 8'b01_10_10_10) begin errors++; $display("FAIL fp_rw: got %b want 01101010", {rw1, rw2, rw3, rw4}); end
            end
        end
    endtask

    task automatic test_a_form();
        int hits;
        logic hit;
        logic [0:83] exp;
        hits = 0;
        for (int op = 0; op < 64; op++) begin
            for (int xo = 0; xo < 32; xo++) begin
                hit = model_is_a(op, xo);
                issue(mk_a(op, xo, xo % 2));
                if (fmt_out === 25'd512) hits++;
                checks++;
                if ((fmt_out === 25'd512) !== hit) begin
                    errors++; $display("FAIL a_fmt op=%0d xo=%0d: got %0d want A=%b", op, xo, fmt_out, hit);
                end
                if (hit) begin
                    exp = '0;
                    exp[0:4]   = 5'd31;
                    exp[10:14] = 5'd31;
                    exp[20]    = 1'(xo % 2);
                    checks++; if (body_out !== exp) begin errors++; $display("FAIL a_body op=%0d xo=%0d: got %h want %h", op, xo, body_out, exp); end
                    checks++; if (opc_out !== {6'(op), 1'b0, 5'(xo)}) begin errors++; $display("FAIL a_opcode op=%0d xo=%0d: got %h", op, xo, opc_out); end
                    checks++; if ({en_out, fu_out, reg4} !== {1'b1, (op == 31) ? 3'd0 : 3'd2, op != 31}) begin
                        errors++; $display("FAIL a_unit op=%0d xo=%0d: got en=%b fu=%0d reg4=%b", op, xo, en_out, fu_out, reg4); end
                end
            end
        end
        checks++; if (hits !== 24) begin errors++; $display("FAIL a_count: got %0d want 24", hits); end
    endtask

    task automatic test_b_form();
        logic aa, lk;
        logic [0:83] exp;
        for (int op = 0; op < 64; op++) begin
            aa = 1'(op % 2);
            lk = 1'((op / 2) % 2);
            issue(mk_b(op, aa, lk));
            checks++;
            if ((fmt_out === 25'd2) !== (op == 16)) begin errors++; $display("FAIL b_fmt op=%0d: got %0d", op, fmt_out); end
            if (op == 16) begin
                exp = '0;
                exp[0:4]   = 5'd31;
                exp[10:25] = 16'hF03C;
                exp[26]    = aa;
                exp[27]    = lk;
                checks++; if (body_out !== exp) begin errors++; $display("FAIL b_body: got %h want %h", body_out, exp); end
                checks++; if ({fu_out, reg1, reg2, opc_out} !== {3'd3, 1'b0, 1'b0, 12'h400}) begin
                    errors++; $display("FAIL b_unit: got fu=%0d reg1=%b reg2=%b opc=%h", fu_out, reg1, reg2, opc_out); end
            end
        end
    endtask

    task automatic test_d_form();
        int hits;
        logic isd, store, upd;
        logic [0:83] exp;
        hits = 0;
        for (int op = 0; op < 64; op++) begin
            isd = model_is_d(op);
            issue(mk_d(op));
            if (fmt_out === 25'd32) hits++;
            checks++;
            if ((fmt_out === 25'd32) !== isd) begin errors++; $display("FAIL d_fmt op=%0d: got %0d want D=%b", op, fmt_out, isd); end
            if (isd) begin
                exp = '0;
                exp[0:4]   = 5'd3;
                exp[5:9]   = 5'd4;
                exp[10:73] = model_imm(op, 16'hF00F);
                checks++; if (body_out !== exp) begin errors++; $display("FAIL d_body op=%0d: got %h want %h", op, body_out, exp); end
                checks++; if (opc_out !== {6'(op), 6'b0}) begin errors++; $display("FAIL d_opcode op=%0d: got %h", op, opc_out); end
                if (op >= 32) begin
                    store = op inside {[36:39], 44, 45, 47, [52:55]};
                    upd   = op inside {33, 35, 37, 39, 41, 43, 45, 49, 51, 53, 55};
                    checks++;
                    if ({fu_out, rw1, rw2} !== {3'd1, store ? 2'b10 : 2'b01, upd ? 2'b11 : 2'b10}) begin
                        errors++; $display("FAIL d_lsu op=%0d: got fu=%0d rw1=%b rw2=%b", op, fu_out, rw1, rw2); end
                end else begin
                    checks++; if (fu_out !== 3'd0) begin errors++; $display("FAIL d_fxu op=%0d: got fu=%0d want 0", op, fu_out); end
                    checks++; if (reg1 !== !(op inside {2, 3, 10, 11})) begin errors++; $display("FAIL d_reg1 op=%0d: got %b", op, reg1); end
                end
                if (op == 14) begin
                    checks++; if (body_out[10:73] !== 64'hFFFF_FFFF_FFFF_F00F) begin errors++; $display("FAIL imm_op14: got %h", body_out[10:73]); end
                end
                if (op == 24) begin
                    checks++; if (body_out[10:73] !== 64'h0000_0000_0000_F00F) begin errors++; $display("FAIL imm_op24: got %h", body_out[10:73]); end
                end
                if (op == 15) begin
                    checks++; if (body_out[10:73] !== 64'hFFFF_FFFF_F00F_0000) begin errors++; $display("FAIL imm_op15: got %h", body_out[10:73]); end
                end
            end
        end
        checks++; if (hits !== 40) begin errors++; $display("FAIL d_count: got %0d want 40", hits); end
    endtask

    task automatic test_back_to_back();
        logic [0:24] exp_fmt [6];
        exp_fmt = '{25'd0, 25'd0, 25'd32, 25'd2, 25'd512, 25'd0};
        enable = 1'b1;
        for (int e = 0; e < 6; e++) begin
            if (e == 0) instruction = mk_d(14);
            if (e == 1) instruction = mk_b(16, 1'b0, 1'b1);
            if (e == 2) instruction = mk_a(59, 18, 0);
            tick();
            if (e == 2) enable = 1'b0;
            checks++;
            if (fmt_out !== exp_fmt[e]) begin errors++; $display("FAIL b2b_fmt edge%0d: got %0d want %0d", e + 1, fmt_out, exp_fmt[e]); end
        end
    endtask

    task automatic test_stall();
        logic [0:6]  exp_en;
        logic [0:24] exp_fmt [7];
        exp_en  = 7'b0011110;
        exp_fmt = '{25'd0, 25'd0, 25'd32, 25'd32, 25'd32, 25'd2, 25'd0};
        instruction = mk_d(14);
        enable = 1'b1;
        for (int e = 0; e < 7; e++) begin
            tick();
            if (e == 0) instruction = mk_b(16, 1'b1, 1'b0);
            if (e == 1) enable = 1'b0;
            if (e == 2) stall = 1'b1;
            if (e == 4) stall = 1'b0;
            checks++;
            if ({en_out, fmt_out} !== {exp_en[e], exp_fmt[e]}) begin
                errors++; $display("FAIL stall edge%0d: got en=%b fmt=%0d want en=%b fmt=%0d", e + 1, en_out, fmt_out, exp_en[e], exp_fmt[e]);
            end
        end
    endtask

    task automatic test_reset_flight();
        address = 64'hFACE; pid = 20'h7;
        instruction = mk_d(14);
        enable = 1'b1;
        tick();
        enable = 1'b0;
        issue_second: begin
            instruction = mk_a(63, 21, 0);
        end
        tick();
        checks++; if (en_out !== 1'b0) begin errors++; $display("FAIL flight_pre: got en=%b want 0", en_out); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({en_out, fmt_out, body_out, addr_out, fu_out, pid_out} !== '0) begin
            errors++; $display("FAIL flight_reset: got en=%b fmt=%0d addr=%h fu=%0d", en_out, fmt_out, addr_out, fu_out);
        end
        for (int e = 0; e < 3; e++) begin
            tick();
            checks++; if (en_out !== 1'b0) begin errors++; $display("FAIL flight_after%0d: got en=%b want 0", e, en_out); end
        end
    endtask

    task automatic test_illegal();
        logic exp_en;
`ifdef ILLEGAL_TRAP_EN
        exp_en = 1'b1;
`else
        exp_en = 1'b0;
`endif
        issue(32'h0000_1234);
        checks++; if (en_out !== exp_en) begin errors++; $display("FAIL illegal_en: got %b want %b", en_out, exp_en); end
        checks++; if (fmt_out !== 25'd0) begin errors++; $display("FAIL illegal_fmt: got %0d want 0", fmt_out); end
        if (exp_en) begin
            checks++;
            if ({fu_out, body_out} !== {3'd7, 32'h0000_1234, 52'b0}) begin
                errors++; $display("FAIL illegal_trap: got fu=%0d body=%h", fu_out, body_out);
            end
        end
    endtask

    initial begin
        enable = 1'b0; stall = 1'b0; reset = 1'b1;
        instruction = '0; address = '0; is64 = 1'b0; pid = '0; tid = '0; maj = '0;
        test_reset();
        test_latency();
        test_a_form();
        test_b_form();
        test_d_form();
        test_back_to_back();
        test_stall();
        test_reset_flight();
        test_illegal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
